// File: rtl/alu_muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide engine and the ALU decoder.
package alu_muldiv_unit_pkg;

    // Engine operation codes
    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_DIV  = 2'b01,
        OP_MOD  = 2'b10,
        OP_RSVD = 2'b11
    } muldiv_op_e;

    // Engine control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } muldiv_state_e;

    // ALU selector codes that are routed to this engine
    localparam logic [3:0] ALU_SEL_MUL = 4'b1100;
    localparam logic [3:0] ALU_SEL_DIV = 4'b1101;
    localparam logic [3:0] ALU_SEL_MOD = 4'b1110;

    // True for the ops that use the divider datapath
    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_MOD);
    endfunction

endpackage

// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between the ALU control side and the mul/div engine.
interface alu_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             zero;
    logic             negative;

    modport master (
        output start, op, dataA, dataB2,
        input  busy, done, result, div_by_zero, zero, negative
    );

    modport slave (
        input  start, op, dataA, dataB2,
        output busy, done, result, div_by_zero, zero, negative
    );
endinterface

// File: rtl/alu_muldiv_unit_step.sv
// One combinational iteration: shift-add for multiply, restoring trial subtract for divide.
module alu_muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   divisor_i,
    input  logic [WIDTH-1:0]   rem_i,
    input  logic [WIDTH-1:0]   quo_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic [WIDTH-1:0]   quo_o
);
    // Multiply: low half of acc holds the remaining multiplier bits, LSB consumed first.
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] mul_hi;

    assign mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, mcand_i};
    assign mul_hi  = acc_i[0] ? mul_sum : {1'b0, acc_i[2*WIDTH-1:WIDTH]};
    assign acc_o   = {mul_hi, acc_i[WIDTH-1:1]};

    // Divide: partial remainder is WIDTH+1 bits since it can reach 2*divisor-1.
    // The remainder is always below the divisor, so bit WIDTH of the trial
    // difference is a reliable borrow (sign) indicator.
    logic [WIDTH:0] part_rem;
    logic [WIDTH:0] trial;
    logic           fits;

    assign part_rem = {rem_i, quo_i[WIDTH-1]};
    assign trial    = part_rem - {1'b0, divisor_i};
    assign fits     = ~trial[WIDTH];
    assign rem_o    = fits ? trial[WIDTH-1:0] : part_rem[WIDTH-1:0];
    assign quo_o    = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative unsigned MUL/DIV/MOD engine: one op in flight, WIDTH iterations per op.
module alu_muldiv_unit
    import alu_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    alu_muldiv_unit_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    muldiv_state_e      state_q;
    muldiv_op_e         op_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;

    muldiv_op_e         op_in;
    logic               short_dbz;
    logic               short_op;
    logic [WIDTH-1:0]   short_res;
    logic [WIDTH-1:0]   final_res;

    assign op_in = muldiv_op_e'(bus.op);

    alu_muldiv_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mcand_i   (a_q),
        .acc_i     (acc_q),
        .divisor_i (b_q),
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .acc_o     (acc_d),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    // Ops that finish without iterating: divide by zero and the reserved code.
    always_comb begin
        short_dbz = is_div_op(op_in) && (bus.dataB2 == '0);
        short_op  = short_dbz || (op_in == OP_RSVD);
        short_res = '0;
        if (short_dbz && (op_in == OP_DIV)) begin
            short_res = '1;
        end else if (short_dbz && (op_in == OP_MOD)) begin
            short_res = bus.dataA;
        end
    end

    // Result taken from the last iteration's outputs, committed on the edge into DONE.
    always_comb begin
        case (op_q)
            OP_MUL:  final_res = acc_d[WIDTH-1:0];
            OP_DIV:  final_res = quo_d;
            default: final_res = rem_d;
        endcase
    end

    // Control FSM, iteration counter, operand and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q   <= op_in;
                        a_q    <= bus.dataA;
                        b_q    <= bus.dataB2;
                        cnt_q  <= CNT_W'(WIDTH - 1);
                        acc_q  <= {{WIDTH{1'b0}}, bus.dataB2};
                        rem_q  <= '0;
                        quo_q  <= bus.dataA;
                        busy_q <= 1'b1;
                        if (short_op) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= short_res;
                            dbz_q    <= short_dbz;
                        end else begin
                            state_q <= ST_RUN;
                            dbz_q   <= 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        state_q  <= ST_DONE;
                        done_q   <= 1'b1;
                        result_q <= final_res;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.zero        = (result_q == '0);
    assign bus.negative    = result_q[WIDTH-1];

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for the iterative mul/div engine.
module tb_alu_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    alu_muldiv_unit_if #(.WIDTH(W)) bus ();

    alu_muldiv_unit #(.WIDTH(W)) dut (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op at cycle 0 and follow it to done, scrambling inputs once accepted.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_cycles;
        lat = -1;
        busy_cycles = 0;
        bus.start  = 1'b1;
        bus.op     = op;
        bus.dataA  = a;
        bus.dataB2 = b;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.op     = 2'b11;
        bus.dataA  = $urandom;
        bus.dataB2 = $urandom;
        for (int n = 1; n <= 60; n++) begin
            if (bus.busy) busy_cycles++;
            if (bus.done) begin
                lat = n;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " busy_cycles"}, 64'(busy_cycles), 64'(exp_lat));
        chk({tag, " result"}, 64'(bus.result), 64'(exp_res));
        chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(exp_dbz));
        chk({tag, " zero"}, 64'(bus.zero), 64'(exp_res == '0));
        chk({tag, " negative"}, 64'(bus.negative), 64'(exp_res[W-1]));
        @(posedge clk);
        #1;
        chk({tag, " idle busy"}, 64'(bus.busy), 64'(0));
        chk({tag, " idle done"}, 64'(bus.done), 64'(0));
        chk({tag, " held result"}, 64'(bus.result), 64'(exp_res));
    endtask

    initial begin
        int n_done;
        int done_at;
        logic [W-1:0] res_at_done;

        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.dataA  = '0;
        bus.dataB2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        chk("reset result", 64'(bus.result), 64'(0));
        chk("reset dbz", 64'(bus.div_by_zero), 64'(0));
        chk("reset zero", 64'(bus.zero), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("mul 7*6",      2'b00, 32'd7,        32'd6,        32'd42,         1'b0, 33);
        run_op("mul ffff*2",   2'b00, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   1'b0, 33);
        run_op("mul max*max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   1'b0, 33);
        run_op("mul 0*5",      2'b00, 32'd0,        32'd5,        32'd0,          1'b0, 33);
        run_op("mul big",      2'b00, 32'h00012345, 32'h00010000, 32'h23450000,   1'b0, 33);
        run_op("div 100/7",    2'b01, 32'd100,      32'd7,        32'd14,         1'b0, 33);
        run_op("mod 100%7",    2'b10, 32'd100,      32'd7,        32'd2,          1'b0, 33);
        run_op("mod 35%7",     2'b10, 32'd35,       32'd7,        32'd0,          1'b0, 33);
        run_op("div 5/0",      2'b01, 32'd5,        32'd0,        32'hFFFFFFFF,   1'b1, 1);
        run_op("mod 5%0",      2'b10, 32'd5,        32'd0,        32'd5,          1'b1, 1);
        run_op("div clr dbz",  2'b01, 32'd7,        32'd100,      32'd0,          1'b0, 33);
        run_op("mod 7%100",    2'b10, 32'd7,        32'd100,      32'd7,          1'b0, 33);
        run_op("div max/1",    2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   1'b0, 33);
        run_op("mod max%max",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,          1'b0, 33);
        run_op("div max/3",    2'b01, 32'hFFFFFFFF, 32'd3,        32'h55555555,   1'b0, 33);
        run_op("rsvd",         2'b11, 32'd9,        32'd4,        32'd0,          1'b0, 1);

        // Start pulsed while a MUL 3*3 is in flight: must be ignored.
        n_done      = 0;
        done_at     = -1;
        res_at_done = '0;
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.dataA  = 32'd3;
        bus.dataB2 = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            if (bus.done) begin
                n_done++;
                done_at     = n;
                res_at_done = bus.result;
            end
            bus.start  = (n >= 5 && n <= 20);
            bus.op     = 2'b01;
            bus.dataA  = 32'd80;
            bus.dataB2 = 32'd0;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
        chk("ignore start done count", 64'(n_done), 64'(1));
        chk("ignore start done cycle", 64'(done_at), 64'(33));
        chk("ignore start result", 64'(res_at_done), 64'(9));
        chk("ignore start idle", 64'(bus.busy), 64'(0));
        run_op("next accepted", 2'b00, 32'd5, 32'd5, 32'd25, 1'b0, 33);

        // Asynchronous reset in the middle of a divide.
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.dataA  = 32'd1000;
        bus.dataB2 = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre-reset busy", 64'(bus.busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(bus.busy), 64'(0));
        chk("abort done", 64'(bus.done), 64'(0));
        chk("abort result", 64'(bus.result), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) n_done++;
        end
        chk("abort no done", 64'(n_done), 64'(0));
        run_op("div 9/3", 2'b01, 32'd9, 32'd3, 32'd3, 1'b0, 33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
